// File: rtl/fpu_pkg.sv
// fpu_pkg -- shared definitions for the normalize/round/pack slice.
//   EXP_W / FRAC_W / MANT_IN_W : field widths of the raw result and packed word
//   EXP_INF                    : biased exponent of infinity
//   *_BIT                      : bit positions inside the raw mantissa
//   fsmState_e                 : normalizer FSM state encoding
//   packResult()               : assembles the IEEE-754 single word, saturating to infinity
package fpu_pkg;

  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int MANT_IN_W = 28;

  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

  localparam int CARRY_BIT  = 27;
  localparam int HIDDEN_BIT = 26;
  localparam int GUARD_BIT  = 2;
  localparam int ROUND_BIT  = 1;
  localparam int STICKY_BIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } fsmState_e;

  // exp carries one extra bit so that overflow past 254 is visible.
  function automatic logic [31:0] packResult(input logic sign,
                                             input logic [EXP_W:0] exp,
                                             input logic [FRAC_W-1:0] frac);
    if (exp >= {1'b0, EXP_INF})
      return {sign, EXP_INF, {FRAC_W{1'b0}}};
    return {sign, exp[EXP_W-1:0], frac};
  endfunction

endpackage

// File: rtl/fpu_norm_round_if.sv
// fpu_norm_round_if -- request/result bundle of the normalizer.
//   start, sign_in, exp_in, mant_in : raw result and request (master -> slave)
//   busy, done, BusW                : status and packed result (slave -> master)
interface fpu_norm_round_if;
  import fpu_pkg::*;

  logic                 start;
  logic                 sign_in;
  logic [EXP_W-1:0]     exp_in;
  logic [MANT_IN_W-1:0] mant_in;
  logic                 busy;
  logic                 done;
  logic [31:0]          BusW;

  modport master (
    output start, sign_in, exp_in, mant_in,
    input  busy, done, BusW
  );

  modport slave (
    input  start, sign_in, exp_in, mant_in,
    output busy, done, BusW
  );

endinterface

// File: rtl/fpu_round_rne.sv
// fpu_round_rne -- combinational mantissa rounder.
//   hiddenIn, fracIn           : normalized significand
//   guardIn, roundIn, stickyIn : bits below the LSB
//   mantOut                    : rounded {hidden, frac}
//   carryOut                   : rounding overflowed out of the hidden bit
// Build option: FPU_ROUND_RNE_EN selects round-to-nearest-even; when it is
// undefined the significand is truncated.
module fpu_round_rne
  import fpu_pkg::*;
(
  input  logic              hiddenIn,
  input  logic [FRAC_W-1:0] fracIn,
  input  logic              guardIn,
  input  logic              roundIn,
  input  logic              stickyIn,
  output logic [FRAC_W:0]   mantOut,
  output logic              carryOut
);

  logic roundUp;

`ifdef FPU_ROUND_RNE_EN
  assign roundUp = guardIn & (roundIn | stickyIn | fracIn[0]);
`else
  // Truncation: the bits below the LSB are discarded.
  assign roundUp = 1'b0 & (guardIn | roundIn | stickyIn);
`endif

  assign {carryOut, mantOut} = {1'b0, hiddenIn, fracIn} + {{(FRAC_W + 1){1'b0}}, roundUp};

endmodule

// File: rtl/fpu_norm_round.sv
// fpu_norm_round -- normalizes a raw FP result one shift per cycle, rounds it
// and packs it into an IEEE-754 single-precision word.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of fpu_norm_round_if (start/sign_in/exp_in/mant_in in,
//           busy/done/BusW out)
// Build option: FPU_ROUND_RNE_EN (round-to-nearest-even, else truncate).
module fpu_norm_round
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  fpu_norm_round_if.slave   bus
);

  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

  fsmState_e            state;
  logic                 signReg;
  logic [EXP_W:0]       expReg;
  logic [MANT_IN_W-1:0] mantReg;
  logic [31:0]          resultReg;
  logic                 busyReg;
  logic                 doneReg;
  logic [31:0]          busWReg;

  logic [FRAC_W:0]   roundedMant;
  logic              roundCarry;
  logic [EXP_W:0]    finalExp;
  logic [FRAC_W-1:0] finalFrac;

  fpu_round_rne uRound (
    .hiddenIn (mantReg[HIDDEN_BIT]),
    .fracIn   (mantReg[HIDDEN_BIT-1:GUARD_BIT+1]),
    .guardIn  (mantReg[GUARD_BIT]),
    .roundIn  (mantReg[ROUND_BIT]),
    .stickyIn (mantReg[STICKY_BIT]),
    .mantOut  (roundedMant),
    .carryOut (roundCarry)
  );

  // A round-up carry out of the hidden bit renormalizes in the same cycle.
  always_comb begin
    finalExp  = expReg + {{EXP_W{1'b0}}, roundCarry};
    finalFrac = roundedMant[FRAC_W-1:0];
    if (roundCarry)
      finalFrac = roundedMant[FRAC_W:1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      signReg   <= 1'b0;
      expReg    <= '0;
      mantReg   <= '0;
      resultReg <= '0;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
      busWReg   <= '0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            signReg <= bus.sign_in;
            expReg  <= {1'b0, bus.exp_in};
            mantReg <= bus.mant_in;
            busyReg <= 1'b1;
            state   <= NORM;
          end
        end
        NORM: begin
          if (mantReg == '0) begin
            resultReg <= {signReg, 31'b0};
            state     <= DONE;
          end else if (mantReg[CARRY_BIT]) begin
            // Old R and S fold into the new sticky bit.
            mantReg <= {1'b0, mantReg[MANT_IN_W-1:2], mantReg[ROUND_BIT] | mantReg[STICKY_BIT]};
            expReg  <= expReg + EXP_ONE;
          end else if (expReg == '0 || (!mantReg[HIDDEN_BIT] && expReg == EXP_ONE)) begin
            // No subnormals: underflow flushes to signed zero.
            resultReg <= {signReg, 31'b0};
            state     <= DONE;
          end else if (!mantReg[HIDDEN_BIT]) begin
            mantReg <= {mantReg[MANT_IN_W-2:0], 1'b0};
            expReg  <= expReg - EXP_ONE;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          resultReg <= packResult(signReg, finalExp, finalFrac);
          state     <= DONE;
        end
        DONE: begin
          busWReg <= resultReg;
          doneReg <= 1'b1;
          busyReg <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busyReg <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busyReg;
  assign bus.done = doneReg;
  assign bus.BusW = busWReg;

endmodule

// File: tb/tb_fpu_norm_round.sv
// tb_fpu_norm_round -- directed self-checking bench for fpu_norm_round.
// Expected rounding result follows FPU_ROUND_RNE_EN at compile time.
module tb_fpu_norm_round;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  fpu_norm_round_if bus ();

  fpu_norm_round dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request and waits (bounded) for done. Inputs change #1 after
  // a rising edge; outputs are sampled at the same offset.
  task automatic issue(input logic s, input logic [7:0] e, input logic [27:0] m,
                       output int lat, output logic [31:0] w, output logic got);
    bus.start   = 1'b1;
    bus.sign_in = s;
    bus.exp_in  = e;
    bus.mant_in = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    got = 1'b0;
    w   = '0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) begin
        got = 1'b1;
        w   = bus.BusW;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.BusW !== 32'h0) begin bad++; $display("FAIL reset_busw got=%h want=00000000", bus.BusW); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] w; logic got;
    bus.start = 1'b1; bus.sign_in = 1'b0; bus.exp_in = 8'd127; bus.mant_in = 28'h4000000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", bus.busy); end
    lat = 1; got = 1'b0; w = '0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) begin got = 1'b1; w = bus.BusW; break; end
    end
    // lat counted the sample edge as 1 above; latency is lat-1.
    total++; if (got !== 1'b1) begin bad++; $display("FAIL basic_timeout got=%b want=1", got); end
    total++; if (w !== 32'h3F800000) begin bad++; $display("FAIL basic_value got=%h want=3f800000", w); end
    total++; if (lat - 1 != 3) begin bad++; $display("FAIL basic_latency got=%0d want=3", lat - 1); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b want=0", bus.busy); end
    @(posedge clk); #1;
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", bus.done); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.BusW !== 32'h3F800000) begin bad++; $display("FAIL basic_hold got=%h want=3f800000", bus.BusW); end
  endtask

  task automatic test_carry();
    int lat; logic [31:0] w; logic got;
    issue(1'b0, 8'd127, 28'h8000000, lat, w, got);
    total++; if (w !== 32'h40000000 || !got) begin bad++; $display("FAIL carry_value got=%h want=40000000", w); end
    total++; if (lat != 4) begin bad++; $display("FAIL carry_latency got=%0d want=4", lat); end
    issue(1'b0, 8'd254, 28'h8000000, lat, w, got);
    total++; if (w !== 32'h7F800000 || !got) begin bad++; $display("FAIL carry_inf got=%h want=7f800000", w); end
    total++; if (lat != 4) begin bad++; $display("FAIL carry_inf_latency got=%0d want=4", lat); end
  endtask

  task automatic test_left_shift();
    int lat; logic [31:0] w; logic got;
    issue(1'b0, 8'd127, 28'h1000000, lat, w, got);
    total++; if (w !== 32'h3E800000 || !got) begin bad++; $display("FAIL left_value got=%h want=3e800000", w); end
    total++; if (lat != 5) begin bad++; $display("FAIL left_latency got=%0d want=5", lat); end
  endtask

  task automatic test_round();
    int lat; logic [31:0] w; logic got;
    logic [31:0] want;
`ifdef FPU_ROUND_RNE_EN
    want = 32'h40000000;
`else
    want = 32'h3FFFFFFF;
`endif
    issue(1'b0, 8'd127, 28'h7FFFFFC, lat, w, got);
    total++; if (w !== want || !got) begin bad++; $display("FAIL round_value got=%h want=%h", w, want); end
    total++; if (lat != 3) begin bad++; $display("FAIL round_latency got=%0d want=3", lat); end
  endtask

  task automatic test_zero_flush();
    int lat; logic [31:0] w; logic got;
    issue(1'b1, 8'd100, 28'h0, lat, w, got);
    total++; if (w !== 32'h80000000 || !got) begin bad++; $display("FAIL neg_zero got=%h want=80000000", w); end
    issue(1'b0, 8'd1, 28'h1000000, lat, w, got);
    total++; if (w !== 32'h00000000 || !got) begin bad++; $display("FAIL flush got=%h want=00000000", w); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] w; logic got;
    issue(1'b0, 8'd127, 28'h4000000, lat, w, got);
    total++; if (w !== 32'h3F800000 || !got) begin bad++; $display("FAIL b2b_first got=%h want=3f800000", w); end
    // Next request raised in the cycle done is high.
    issue(1'b1, 8'd127, 28'h8000000, lat, w, got);
    total++; if (w !== 32'hC0000000 || !got) begin bad++; $display("FAIL b2b_second got=%h want=c0000000", w); end
    total++; if (lat != 4) begin bad++; $display("FAIL b2b_latency got=%0d want=4", lat); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] w; logic got;
    logic sawDone;
    sawDone = 1'b0;
    bus.start = 1'b1; bus.sign_in = 1'b0; bus.exp_in = 8'd127; bus.mant_in = 28'h1000000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    if (bus.done) sawDone = 1'b1;
    reset = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    if (bus.done) sawDone = 1'b1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
    total++; if (bus.BusW !== 32'h0) begin bad++; $display("FAIL rstmid_busw got=%h want=00000000", bus.BusW); end
    reset = 1'b0;
    bus.start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.done) sawDone = 1'b1;
    end
    total++; if (sawDone !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", sawDone); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_start_ignored got=%b want=0", bus.busy); end
    issue(1'b0, 8'd127, 28'h1000000, lat, w, got);
    total++; if (w !== 32'h3E800000 || !got) begin bad++; $display("FAIL rstmid_rerun got=%h want=3e800000", w); end
    total++; if (lat != 5) begin bad++; $display("FAIL rstmid_latency got=%0d want=5", lat); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.start   = 1'b0;
    bus.sign_in = 1'b0;
    bus.exp_in  = '0;
    bus.mant_in = '0;
    test_reset();
    test_basic();
    test_carry();
    test_left_shift();
    test_round();
    test_zero_flush();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
